// File: rtl/cpu_pkg.sv
// Shared definitions for the data-memory arbiter: ownership state encoding and
// the address bit that selects peripheral space.
package cpu_pkg;

   typedef enum logic {
      S_CPU = 1'b0,
      S_DMA = 1'b1
   } arb_state_t;

   localparam int PERIPH_BIT = 30;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear and asynchronous active-low reset.
// A clear and an increment in the same cycle load 1, so a first event is never lost.
module sat_counter #(
   parameter int W     = 4,
   parameter int LIMIT = 4
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;
   logic [W-1:0] w_base;

   assign w_base = i_clr ? '0 : r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_inc && (w_base != W'(LIMIT))) begin
         r_cnt <= w_base + 1'b1;
      end else begin
         r_cnt <= w_base;
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and a DMA master.
// Optional macro DMEM_ARB_STATS_EN adds stall/beat statistics counters.
module dmem_arbiter
   import cpu_pkg::*;
#(
   parameter int MAX_WAIT  = 4,
   parameter int BURST_MAX = 8,
   parameter int CW        = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_rd,
   input  logic        cpu_wr,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        dma_req,
   input  logic        dma_wr,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   input  logic        dma_last,
   output logic        dma_gnt,
   output logic [31:0] dma_rdata,
   output logic        dma_rvalid,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output arb_state_t  dbg_state
`ifdef DMEM_ARB_STATS_EN
   ,
   output logic [31:0] stat_stall,
   output logic [31:0] stat_beats
`endif
);

   localparam logic LP_MULTI_BEAT = (BURST_MAX > 1);

   // Handshake: D presents dma_* with dma_req and holds them stable; a beat
   // transfers in the cycle dma_gnt=1. A granted read returns dma_rdata one
   // cycle later, qualified by a single-cycle dma_rvalid.
   arb_state_t    r_state;
   arb_state_t    w_state_nxt;
   logic          w_cpu_access;
   logic          w_gnt;
   logic          w_stall;
   logic          w_wait_max;
   logic          w_beat_final;
   logic          w_wait_clr;
   logic          w_wait_inc;
   logic          w_beat_clr;
   logic [CW-1:0] w_wait_cnt;
   logic [CW-1:0] w_beat_cnt;
   logic          r_rvalid;
   logic [31:0]   r_rdata;

   assign w_cpu_access = (cpu_rd | cpu_wr) & ~cpu_addr[PERIPH_BIT];
   assign w_wait_max   = (w_wait_cnt == CW'(MAX_WAIT));
   assign w_beat_final = (w_beat_cnt == CW'(BURST_MAX - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_CPU;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gnt       = 1'b0;
      w_stall     = 1'b0;
      case (r_state)
         S_CPU: begin
            w_gnt = dma_req & (~w_cpu_access | w_wait_max);
            if (w_gnt & ~dma_last & LP_MULTI_BEAT) begin
               w_state_nxt = S_DMA;
            end
         end
         S_DMA: begin
            w_gnt = dma_req;
            if (~dma_req | dma_last | w_beat_final) begin
               w_state_nxt = S_CPU;
            end
         end
         default: w_state_nxt = S_CPU;
      endcase
      // Nothing may be granted or frozen while reset is held.
      if (!reset) begin
         w_gnt = 1'b0;
      end
      w_stall = reset & w_cpu_access & (w_gnt | (r_state == S_DMA));
   end

   assign w_wait_clr = w_gnt | ~dma_req;
   assign w_wait_inc = (r_state == S_CPU) & dma_req & w_cpu_access & ~w_gnt;
   assign w_beat_clr = (r_state == S_CPU);

   sat_counter #(.W(CW), .LIMIT(MAX_WAIT)) u_wait_cnt (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_clr   (w_wait_clr),
      .i_inc   (w_wait_inc),
      .o_cnt   (w_wait_cnt)
   );

   // Loaded with 1 on the entry beat, so it counts every beat of the period.
   sat_counter #(.W(CW), .LIMIT(BURST_MAX)) u_beat_cnt (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_clr   (w_beat_clr),
      .i_inc   (w_gnt),
      .o_cnt   (w_beat_cnt)
   );

   always_comb begin
      mem_rd    = cpu_rd & ~cpu_addr[PERIPH_BIT];
      mem_wr    = cpu_wr & ~cpu_addr[PERIPH_BIT];
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      if (w_gnt) begin
         mem_rd    = ~dma_wr;
         mem_wr    = dma_wr;
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_rvalid <= w_gnt & ~dma_wr;
         if (w_gnt & ~dma_wr) begin
            r_rdata <= mem_rdata;
         end
      end
   end

`ifdef DMEM_ARB_STATS_EN
   logic [31:0] r_stat_stall;
   logic [31:0] r_stat_beats;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stat_stall <= '0;
         r_stat_beats <= '0;
      end else begin
         r_stat_stall <= r_stat_stall + {31'd0, w_stall};
         r_stat_beats <= r_stat_beats + {31'd0, w_gnt};
      end
   end

   assign stat_stall = r_stat_stall;
   assign stat_beats = r_stat_beats;
`endif

   assign dma_gnt    = w_gnt;
   assign cpu_stall  = w_stall;
   assign cpu_rdata  = mem_rdata;
   assign dma_rdata  = r_rdata;
   assign dma_rvalid = r_rvalid;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter against an ownership-level reference model.
// Define DMEM_ARB_STATS_EN in both bench and RTL to also check the statistics counters.
`timescale 1ns/1ps
module tb_dmem_arbiter;
   import cpu_pkg::*;

   localparam int MAX_WAIT  = 4;
   localparam int BURST_MAX = 8;
   localparam int CW        = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cpu_rd, cpu_wr, dma_req, dma_wr, dma_last;
   logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        cpu_stall, dma_gnt, dma_rvalid, mem_rd, mem_wr;
   arb_state_t  dbg_state;
`ifdef DMEM_ARB_STATS_EN
   logic [31:0] stat_stall, stat_beats;
`endif

   always #5 clk = ~clk;

   dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX), .CW(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_rd     (cpu_rd),
      .cpu_wr     (cpu_wr),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .dma_req    (dma_req),
      .dma_wr     (dma_wr),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_last   (dma_last),
      .dma_gnt    (dma_gnt),
      .dma_rdata  (dma_rdata),
      .dma_rvalid (dma_rvalid),
      .mem_rd     (mem_rd),
      .mem_wr     (mem_wr),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .dbg_state  (dbg_state)
`ifdef DMEM_ARB_STATS_EN
      ,
      .stat_stall (stat_stall),
      .stat_beats (stat_beats)
`endif
   );

   // Data memory stand-in: combinational read, write at posedge.
   logic [31:0] mem_arr [0:255];
   assign mem_rdata = mem_arr[mem_addr[7:0]];
   always @(posedge clk) if (mem_wr) mem_arr[mem_addr[7:0]] <= mem_wdata;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: who owns the memory, how long D has been refused, beats this period.
   bit          m_own_d = 1'b0;
   int          m_denied = 0;
   int          m_beats = 0;
   bit          m_rvalid = 1'b0;
   logic [31:0] m_rdata = '0;
   int          m_stall_cnt = 0;
   int          m_beat_cnt = 0;
   bit          last_gnt = 1'b0;

   logic        obs_gnt, obs_stall;
   logic [31:0] obs_mem_addr, obs_cpu_rdata;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic set_cpu(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
   endtask

   task automatic set_dma(input logic req, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic last);
      dma_req = req; dma_wr = wr; dma_addr = a; dma_wdata = d; dma_last = last;
   endtask

   task automatic model_reset();
      m_own_d = 1'b0; m_denied = 0; m_beats = 0; m_rvalid = 1'b0; m_rdata = '0;
      m_stall_cnt = 0; m_beat_cnt = 0; last_gnt = 1'b0;
   endtask

   // One clock: inputs already driven at posedge+1; combinational checks at negedge,
   // registered checks at the following posedge+1.
   task automatic cycle();
      bit          acc, eg, es, erd, ewr;
      logic [31:0] ea, ew;
      @(negedge clk);
      acc = (cpu_rd || cpu_wr) && !cpu_addr[30];
      eg  = m_own_d ? dma_req : (dma_req && (!acc || m_denied >= MAX_WAIT));
      es  = acc && (eg || m_own_d);
      if (eg) begin
         ea = dma_addr; ew = dma_wdata; erd = !dma_wr; ewr = dma_wr;
      end else begin
         ea = cpu_addr; ew = cpu_wdata; erd = cpu_rd && !cpu_addr[30]; ewr = cpu_wr && !cpu_addr[30];
      end
      obs_gnt = dma_gnt; obs_stall = cpu_stall; obs_mem_addr = mem_addr; obs_cpu_rdata = cpu_rdata;
      check("dma_gnt", {31'd0, dma_gnt}, {31'd0, eg});
      check("cpu_stall", {31'd0, cpu_stall}, {31'd0, es});
      check("mem_rd", {31'd0, mem_rd}, {31'd0, erd});
      check("mem_wr", {31'd0, mem_wr}, {31'd0, ewr});
      check("mem_addr", mem_addr, ea);
      check("mem_wdata", mem_wdata, ew);
      check("cpu_rdata", cpu_rdata, mem_arr[ea[7:0]]);
      m_rvalid = eg && !dma_wr;
      if (m_rvalid) m_rdata = mem_arr[dma_addr[7:0]];
      if (es) m_stall_cnt++;
      if (eg) m_beat_cnt++;
      if (eg) begin
         m_denied = 0;
         if (!m_own_d) begin
            if (!dma_last && BURST_MAX > 1) begin m_own_d = 1'b1; m_beats = 1; end
         end else begin
            m_beats++;
            if (dma_last || m_beats == BURST_MAX) m_own_d = 1'b0;
         end
      end else begin
         if (!dma_req) m_denied = 0;
         else if (acc && !m_own_d && m_denied < MAX_WAIT) m_denied++;
         if (m_own_d && !dma_req) m_own_d = 1'b0;
      end
      last_gnt = eg;
      @(posedge clk); #1;
      check("dma_rvalid", {31'd0, dma_rvalid}, {31'd0, m_rvalid});
      check("dma_rdata", dma_rdata, m_rdata);
      check("state", {31'd0, dbg_state}, {31'd0, m_own_d});
   endtask

   initial begin
      int grants, cyc, first_g;
      int g_idx [$];
      logic [31:0] bdata [0:11];
      for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
      mem_arr[8'h20] = 32'h1234_5678;
      set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
      set_dma(1'b1, 1'b0, 32'h20, 32'h0, 1'b1);

      // Reset state, with a pending D request that must not be granted.
      #2;
      check("rst_gnt", {31'd0, dma_gnt}, 32'd0);
      check("rst_stall", {31'd0, cpu_stall}, 32'd0);
      check("rst_rvalid", {31'd0, dma_rvalid}, 32'd0);
      check("rst_rdata", dma_rdata, 32'd0);
      check("rst_state", {31'd0, dbg_state}, {31'd0, S_CPU});
      set_dma(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
      model_reset();

      // 1: CPU store then load, D idle.
      set_cpu(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
      cycle();
      set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
      cycle();
      check("t1_load", obs_cpu_rdata, 32'hDEAD_BEEF);

      // 2: single-beat D read while CPU idle.
      set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
      set_dma(1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
      cycle();
      check("t2_gnt", {31'd0, obs_gnt}, 32'd1);
      check("t2_rdata", dma_rdata, 32'h1234_5678);
      check("t2_state", {31'd0, dbg_state}, {31'd0, S_CPU});
      set_dma(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      cycle();

      // 3: CPU busy every cycle; D single beats win every fifth cycle.
      set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
      set_dma(1'b1, 1'b0, 32'h20, 32'h0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         cycle();
         check("t3_gnt", {31'd0, obs_gnt}, (i == 4 || i == 9) ? 32'd1 : 32'd0);
         check("t3_stall", {31'd0, obs_stall}, (i == 4 || i == 9) ? 32'd1 : 32'd0);
      end
      set_dma(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      cycle();

      // 4: 12-beat write burst against continuous CPU loads.
      grants = 0; cyc = 0;
      for (int i = 0; i < 12; i++) bdata[i] = $urandom;
      set_dma(1'b1, 1'b1, 32'h80, bdata[0], 1'b0);
      while (grants < 12 && cyc < 40) begin
         cycle();
         if (obs_gnt) begin
            g_idx.push_back(cyc);
            grants++;
            if (grants < 12) set_dma(1'b1, 1'b1, 32'h80 + grants, bdata[grants], grants == 11);
            else set_dma(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
         end
         cyc++;
      end
      check("t4_beats", grants, 32'd12);
      first_g = (g_idx.size() > 0) ? g_idx[0] : -1;
      check("t4_first", first_g, 32'd4);
      check("t4_gap", (g_idx.size() == 12) ? (g_idx[8] - g_idx[7]) : -1, 32'd5);
      check("t4_end", (g_idx.size() == 12) ? g_idx[11] : -1, 32'd19);
      check("t4_mem", mem_arr[8'h8B], bdata[11]);
      set_dma(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      cycle();

      // 5: peripheral store bypasses arbitration alongside a D write.
      set_cpu(1'b0, 1'b1, 32'h4000_0000, 32'h5555_AAAA);
      set_dma(1'b1, 1'b1, 32'h30, 32'hCAFE_F00D, 1'b1);
      cycle();
      check("t5_gnt", {31'd0, obs_gnt}, 32'd1);
      check("t5_stall", {31'd0, obs_stall}, 32'd0);
      check("t5_addr", obs_mem_addr, 32'h30);
      set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
      set_dma(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      cycle();

      // 6: async reset while beat 3 of a read burst is on offer.
      set_dma(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
      cycle();
      set_dma(1'b1, 1'b0, 32'h41, 32'h0, 1'b0);
      cycle();
      set_dma(1'b1, 1'b0, 32'h42, 32'h0, 1'b0);
      set_cpu(1'b1, 1'b0, 32'h10, 32'h0);
      #2 reset = 1'b0;
      #1;
      model_reset();
      check("t6_state", {31'd0, dbg_state}, {31'd0, S_CPU});
      check("t6_rvalid", {31'd0, dma_rvalid}, 32'd0);
      check("t6_rdata", dma_rdata, 32'd0);
      check("t6_gnt", {31'd0, dma_gnt}, 32'd0);
      check("t6_stall", {31'd0, cpu_stall}, 32'd0);
      check("t6_mem_addr", mem_addr, 32'h10);
`ifdef DMEM_ARB_STATS_EN
      check("t6_stat_stall", stat_stall, 32'd0);
      check("t6_stat_beats", stat_beats, 32'd0);
`endif
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      cycle();
      check("t6_cpu_owns", {31'd0, obs_gnt}, 32'd0);
      set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
      set_dma(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      cycle();

      // Randomized traffic; D holds its request until granted.
      for (int n = 0; n < 300; n++) begin
         int k;
         k = $urandom_range(0, 3);
         set_cpu(k == 1 || k == 3, k == 2, {1'b0, ($urandom_range(0, 4) == 0), 22'd0, 8'($urandom)},
                 $urandom);
         if (!(dma_req && !last_gnt)) begin
            set_dma($urandom_range(0, 3) != 0, 1'($urandom), {24'd0, 8'($urandom)}, $urandom,
                    $urandom_range(0, 5) == 0);
         end
         cycle();
      end
`ifdef DMEM_ARB_STATS_EN
      check("stat_stall", stat_stall, m_stall_cnt);
      check("stat_beats", stat_beats, m_beat_cnt);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
